// File: rtl/boss_fight_hp_ctrl.sv
// Boss/player HP owner and round sequencer with a round-robin boss-hit arbiter.
// Define BOSS_HP_INVULN_EN to build the player invulnerability window.
module boss_fight_hp_ctrl #(
  parameter int unsigned BOSS_HP_INIT   = 1000,
  parameter int unsigned PLAYER_HP_INIT = 3,
  parameter int unsigned BULLET_DMG     = 10,
  parameter int unsigned INVULN_CYCLES  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] boss_hit_req,
  output logic [3:0] boss_hit_gnt,
  input  logic       player_hit_req,
  output logic       player_hit_ack,
  output logic [9:0] bossHP,
  output logic [1:0] playerHP,
  output logic       invuln,
  output logic       round_active
);

  if (BOSS_HP_INIT > 1023) begin : g_bad_boss
    $error("BOSS_HP_INIT must fit in 10 bits");
  end
  if (PLAYER_HP_INIT < 1 || PLAYER_HP_INIT > 3) begin : g_bad_player
    $error("PLAYER_HP_INIT must be 1..3");
  end
  if (BULLET_DMG < 1 || BULLET_DMG > 1023) begin : g_bad_dmg
    $error("BULLET_DMG must be 1..1023");
  end
  if (INVULN_CYCLES < 1) begin : g_bad_inv
    $error("INVULN_CYCLES must be >= 1");
  end

  localparam logic [9:0] BOSS_INIT = 10'(BOSS_HP_INIT);
  localparam logic [1:0] PLAY_INIT = 2'(PLAYER_HP_INIT);
  localparam logic [9:0] DMG       = 10'(BULLET_DMG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, idx;
  logic [9:0] boss_n;
  logic [1:0] player_n;
  logic       hit_ok;

  assign player_hit_ack = player_hit_req;

  // Search from ptr upward; first requester wins
  always_comb begin
    boss_hit_gnt = '0;
    ptr_n        = ptr;
    idx          = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (boss_hit_req[idx] && boss_hit_gnt == 4'd0) begin
        boss_hit_gnt[idx] = 1'b1;
        ptr_n             = idx + 2'd1;
      end
    end
  end

`ifdef BOSS_HP_INVULN_EN
  assign hit_ok = player_hit_req && !invuln;
`else
  assign hit_ok = player_hit_req;
`endif

  always_comb begin
    state_n  = state;
    boss_n   = bossHP;
    player_n = playerHP;
    unique case (state)
      IDLE: begin
        boss_n   = BOSS_INIT;
        player_n = PLAY_INIT;
        if (start) state_n = PLAY;
      end
      PLAY: begin
        if (|boss_hit_gnt)
          boss_n = (bossHP <= DMG) ? 10'd0 : bossHP - DMG;
        if (hit_ok)
          player_n = (playerHP == 2'd0) ? 2'd0 : playerHP - 2'd1;
        if (boss_n == 10'd0 || player_n == 2'd0)
          state_n = OVER;
      end
      OVER: begin
        if (start) begin
          boss_n   = BOSS_INIT;
          player_n = PLAY_INIT;
          state_n  = PLAY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      bossHP       <= BOSS_INIT;
      playerHP     <= PLAY_INIT;
      round_active <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      bossHP       <= boss_n;
      playerHP     <= player_n;
      round_active <= (state_n == PLAY);
    end
  end

`ifdef BOSS_HP_INVULN_EN
  localparam int unsigned CW = $clog2(INVULN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic          invuln_n;

  // Window ends on the edge where the counter has run down to 0
  always_comb begin
    invuln_n = invuln;
    cnt_n    = cnt;
    if (invuln) begin
      if (cnt == '0) invuln_n = 1'b0;
      else           cnt_n    = cnt - 1'b1;
    end
    if (state == IDLE || (state == OVER && start)) begin
      invuln_n = 1'b0;
      cnt_n    = '0;
    end else if (state == PLAY && hit_ok) begin
      invuln_n = 1'b1;
      cnt_n    = CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      invuln <= 1'b0;
      cnt    <= '0;
    end else begin
      invuln <= invuln_n;
      cnt    <= cnt_n;
    end
  end
`else
  assign invuln = 1'b0;
`endif

endmodule

// File: tb/tb_boss_fight_hp_ctrl.sv
// Directed bench for boss_fight_hp_ctrl: a default-HP instance and a
// low-HP instance exercise arbitration, damage, saturation and rounds.
module tb_boss_fight_hp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       d_rst, d_start, d_preq;
  logic [3:0] d_breq, d_gnt;
  logic       d_ack, d_inv, d_act;
  logic [9:0] d_boss;
  logic [1:0] d_play;

  logic       s_rst, s_start, s_preq;
  logic [3:0] s_breq, s_gnt;
  logic       s_ack, s_inv, s_act;
  logic [9:0] s_boss;
  logic [1:0] s_play;

  boss_fight_hp_ctrl #(
    .BOSS_HP_INIT(1000), .PLAYER_HP_INIT(3),
    .BULLET_DMG(10), .INVULN_CYCLES(4)
  ) u_dut (
    .clk(clk), .rst(d_rst), .start(d_start),
    .boss_hit_req(d_breq), .boss_hit_gnt(d_gnt),
    .player_hit_req(d_preq), .player_hit_ack(d_ack),
    .bossHP(d_boss), .playerHP(d_play),
    .invuln(d_inv), .round_active(d_act)
  );

  boss_fight_hp_ctrl #(
    .BOSS_HP_INIT(15), .PLAYER_HP_INIT(3),
    .BULLET_DMG(10), .INVULN_CYCLES(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start),
    .boss_hit_req(s_breq), .boss_hit_gnt(s_gnt),
    .player_hit_req(s_preq), .player_hit_ack(s_ack),
    .bossHP(s_boss), .playerHP(s_play),
    .invuln(s_inv), .round_active(s_act)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    d_rst = 1'b1; d_start = 1'b0; d_preq = 1'b0; d_breq = 4'd0;
    s_rst = 1'b1; s_start = 1'b0; s_preq = 1'b0; s_breq = 4'd0;
    tick();
    chk("rst_boss", d_boss, 1000);
    chk("rst_player", d_play, 3);
    chk("rst_invuln", d_inv, 0);
    chk("rst_active", d_act, 0);
    d_rst = 1'b0;

    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("start_active", d_act, 1);
    chk("start_boss", d_boss, 1000);

    d_breq = 4'hF; #1;
    chk("rr_gnt0", d_gnt, 4'b0001);
    tick();
    chk("rr_boss990", d_boss, 990);
    d_breq = 4'hE; #1;
    chk("rr_gnt1", d_gnt, 4'b0010);
    tick();
    chk("rr_boss980", d_boss, 980);
    d_breq = 4'hC; #1;
    chk("rr_gnt2", d_gnt, 4'b0100);
    tick();
    chk("rr_boss970", d_boss, 970);
    d_breq = 4'h8; #1;
    chk("rr_gnt3", d_gnt, 4'b1000);
    tick();
    chk("rr_boss960", d_boss, 960);
    d_breq = 4'h0; #1;
    chk("gnt_none", d_gnt, 4'b0000);

    d_breq = 4'hA; #1;
    chk("rr_wrap_gnt1", d_gnt, 4'b0010);
    tick();
    chk("rr_boss950", d_boss, 950);
    d_breq = 4'h8; #1;
    chk("rr_wrap_gnt3", d_gnt, 4'b1000);
    tick();
    chk("rr_boss940", d_boss, 940);
    d_breq = 4'h0;

`ifdef BOSS_HP_INVULN_EN
    d_preq = 1'b1; #1;
    chk("ack_hit1", d_ack, 1);
    tick();
    d_preq = 1'b0;
    chk("inv_hp2", d_play, 2);
    chk("inv_c1", d_inv, 1);
    tick();
    chk("inv_c2", d_inv, 1);
    d_preq = 1'b1; #1;
    chk("ack_discard", d_ack, 1);
    tick();
    d_preq = 1'b0;
    chk("inv_discard_hp", d_play, 2);
    chk("inv_c3", d_inv, 1);
    tick();
    chk("inv_c4", d_inv, 1);
    tick();
    chk("inv_c5_clear", d_inv, 0);
    d_preq = 1'b1;
    tick();
    d_preq = 1'b0;
    chk("inv_hp1", d_play, 1);
    chk("inv_reload", d_inv, 1);
    repeat (4) tick();
    chk("inv_clear2", d_inv, 0);
    d_preq = 1'b1;
    tick();
    d_preq = 1'b0;
    chk("inv_hp0", d_play, 0);
    chk("inv_over", d_act, 0);
`else
    d_preq = 1'b1; #1;
    chk("ack_hit1", d_ack, 1);
    tick();
    chk("noinv_hp2", d_play, 2);
    chk("noinv_inv", d_inv, 0);
    tick();
    chk("noinv_hp1", d_play, 1);
    tick();
    d_preq = 1'b0;
    chk("noinv_hp0", d_play, 0);
    chk("noinv_inv_end", d_inv, 0);
    chk("noinv_over", d_act, 0);
`endif

    d_breq = 4'h1; #1;
    chk("over_gnt", d_gnt, 4'b0001);
    tick();
    d_breq = 4'h0;
    chk("over_boss_frozen", d_boss, 940);
    chk("over_player_frozen", d_play, 0);

    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("restart_boss", d_boss, 1000);
    chk("restart_player", d_play, 3);
    chk("restart_active", d_act, 1);
    chk("restart_invuln", d_inv, 0);

    d_breq = 4'h1;
    tick();
    chk("pre_rst_boss", d_boss, 990);
    d_breq = 4'h6;
    d_rst  = 1'b1;
    tick();
    d_rst  = 1'b0;
    d_breq = 4'hF;
    chk("midrst_boss", d_boss, 1000);
    chk("midrst_player", d_play, 3);
    chk("midrst_active", d_act, 0);
    #1;
    chk("midrst_ptr", d_gnt, 4'b0001);
    tick();
    chk("idle_no_dmg", d_boss, 1000);
    d_breq  = 4'h0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("post_rst_play", d_act, 1);

    s_rst   = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("s_boss15", s_boss, 15);
    chk("s_active", s_act, 1);
    s_preq = 1'b1;
    tick();
    s_preq = 1'b0;
    chk("s_hp2", s_play, 2);
    tick(); tick();
    s_preq = 1'b1;
    tick();
    s_preq = 1'b0;
    chk("s_hp1", s_play, 1);
    tick();
    s_breq = 4'h1; #1;
    chk("s_gnt0", s_gnt, 4'b0001);
    tick();
    s_breq = 4'h0;
    chk("s_boss5", s_boss, 5);
    tick();
    chk("s_inv_done", s_inv, 0);
    s_breq = 4'h2;
    s_preq = 1'b1; #1;
    chk("s_both_gnt", s_gnt, 4'b0010);
    chk("s_both_ack", s_ack, 1);
    tick();
    s_breq = 4'h0;
    s_preq = 1'b0;
    chk("s_both_boss0", s_boss, 0);
    chk("s_both_player0", s_play, 0);
    chk("s_both_over", s_act, 0);
    s_breq = 4'h4; #1;
    chk("s_over_gnt", s_gnt, 4'b0100);
    tick();
    s_breq = 4'h0;
    chk("s_over_boss0", s_boss, 0);

    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("s_r2_boss", s_boss, 15);
    chk("s_r2_player", s_play, 3);
    s_breq = 4'h8; #1;
    chk("s_r2_gnt3", s_gnt, 4'b1000);
    tick();
    chk("s_r2_boss5", s_boss, 5);
    s_breq = 4'h1;
    tick();
    s_breq = 4'h0;
    chk("s_sat_boss0", s_boss, 0);
    chk("s_sat_over", s_act, 0);
    chk("s_sat_player", s_play, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
